ro_pair_counter: RTL

- Measurement stage directly downstream of the two gated ring oscillators in the RO-PUF array.
- Enables one oscillator pair, lets the pair settle, then counts rising edges of each oscillator over a fixed window of system clocks.
- Compares the two counts and emits one PUF response bit plus the raw counts.
- Sits between the oscillator instances and the response/key-assembly logic; the start/done handshake is driven by the PUF controller.

---
 rtl/ro_pair_counter_if.sv | 28 ++
 rtl/ro_pair_counter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ro_pair_counter_if.sv
// Controller-side bus of the RO pair counter: measurement request and results.
`timescale 1ns/1ps

// Handshake: start is a one-cycle request from the controller, taken only while
// busy=0 (a start seen while busy=1 is dropped, never queued). done is a
// one-cycle pulse from the counter. resp, tie, count_a and count_b are valid
// from the done cycle and hold until the next accepted start.
interface ro_pair_counter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic             resp;
  logic             tie;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;

  modport master (
    output start,
    input  busy, done, resp, tie, count_a, count_b
  );

  modport slave (
    input  start,
    output busy, done, resp, tie, count_a, count_b
  );
endinterface

// File: rtl/ro_pair_counter.sv
// Measures one ring-oscillator pair: enable, settle, count rising edges of each
// oscillator over a fixed clk window, then compare the two counts.
`timescale 1ns/1ps

module ro_pair_counter #(
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SETTLE      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  ro_pair_counter_if.slave   bus,
  input  logic               osc_a,
  input  logic               osc_b,
  output logic               en_a,
  output logic               en_b,
  output logic [1:0]         dbg_state
);

  localparam int MAX_T = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]       cnt_b_q, cnt_b_d;
  logic                   resp_q, resp_d;
  logic                   tie_q, tie_d;
  logic                   en_q, busy_q, done_q;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic                   hist_a_q, hist_b_q;
  logic                   edge_a, edge_b;

  // Oscillator synchronizers plus one history flop each; runs in every state
  // so the first counted cycle never sees a stale history bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      hist_a_q <= 1'b0;
      hist_b_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], osc_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], osc_b};
      hist_a_q <= sync_a_q[SYNC_STAGES-1];
      hist_b_q <= sync_b_q[SYNC_STAGES-1];
    end
  end

  assign edge_a = sync_a_q[SYNC_STAGES-1] & ~hist_a_q;
  assign edge_b = sync_b_q[SYNC_STAGES-1] & ~hist_b_q;

  // State, timer, counters and results; the flag outputs are registered from
  // the next state so they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      resp_q  <= 1'b0;
      tie_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      en_q    <= (state_d == S_SETTLE) || (state_d == S_COUNT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Next-state and datapath: settle for SETTLE cycles, count for WINDOW
  // cycles (last cycle included), then resolve resp/tie on entry to DONE.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_a_d = '0;
          cnt_b_d = '0;
          resp_d  = 1'b0;
          tie_d   = 1'b0;
          timer_d = SETTLE_LD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) begin
          timer_d = WINDOW_LD;
          state_d = S_COUNT;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_COUNT: begin
        if (edge_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (edge_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
        if (timer_q == '0) begin
          resp_d  = (cnt_a_d > cnt_b_d);
          tie_d   = (cnt_a_d == cnt_b_d);
          state_d = S_DONE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign en_a        = en_q;
  assign en_b        = en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.resp    = resp_q;
  assign bus.tie     = tie_q;
  assign bus.count_a = cnt_a_q;
  assign bus.count_b = cnt_b_q;
  assign dbg_state   = state_q;

endmodule
